stream_demux2: RTL

Steers one 8-bit valid/ready byte stream to one of two downstream ports, choosing the port per packet from `sel` and holding that choice until the packet's last beat. It is the fan-out counterpart to the 8-bit 2-to-1 multiplexer on the gathering side: the mux merges two byte sources onto one bus, and this block splits one bus back out to two sinks. Each output is registered for timing closure, and a per-port packet counter is kept for link bring-up.

---
 rtl/stream_demux_pkg.sv | 14 +
 rtl/demux_out_stage.sv | 70 +++++++
 rtl/stream_demux2.sv | 118 +++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the two-port byte-stream demultiplexer.
//   demux_state_t : packet framing state (between packets / inside a packet)
//   PORT0, PORT1  : route encodings matching the sel input
package stream_demux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } demux_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/demux_out_stage.sv
// One-entry registered output slice with a delivered-packet counter.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   load                : an accepted input beat is routed to this slice this cycle
//   in_data, in_last    : beat to capture on load
//   out_ready           : downstream accepts the held beat
//   out_data/valid/last : registered output beat
//   pkt_cnt             : packets whose last beat was loaded into this slice (wraps)
//   can_load            : slice is empty or draining this cycle, so it may take a beat
module demux_out_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             can_load
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    // A load in the same cycle as a drain wins: valid stays high with the new beat.
    if (load) begin
      data_d  = in_data;
      last_d  = in_last;
      valid_d = 1'b1;
      if (in_last) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign pkt_cnt   = cnt_q;
  assign can_load  = !valid_q || out_ready;

endmodule

// File: rtl/stream_demux2.sv
// Steers one valid/ready byte stream to one of two registered output ports.
// The port is chosen from sel on a packet's first beat and held until its last beat.
// Ports:
//   clk, reset                     : rising-edge clock, synchronous active-high reset
//   sel                            : route of the packet starting now (0 -> port 0)
//   in_data, in_valid, in_last     : input beat
//   in_ready                       : input beat accepted when in_valid && in_ready
//   outN_data, outN_valid, outN_last, outN_ready : registered output port N
//   pkt_cntN                       : packets fully loaded into port N (wraps)
module stream_demux2
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  demux_state_t state_q, state_d;
  logic         route_q, route_d;
  logic         target;
  logic         accept;
  logic         load0, load1;
  logic         can_load0, can_load1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      route_q <= PORT0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    unique case (state_q)
      IDLE: begin
        // Single-beat packets never leave IDLE.
        if (accept && !in_last) begin
          state_d = BUSY;
          route_d = sel;
        end
      end
      BUSY: begin
        if (accept && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: target select, in_ready mux and per-port loads
  always_comb begin
    target   = (state_q == IDLE) ? sel : route_q;
    // Only the target port's readiness gates the input.
    in_ready = !reset && ((target == PORT1) ? can_load1 : can_load0);
    accept   = in_valid && in_ready;
    load0    = accept && (target == PORT0);
    load1    = accept && (target == PORT1);
  end

  demux_out_stage #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_stage0 (
    .clk      (clk),
    .reset    (reset),
    .load     (load0),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_ready(out0_ready),
    .out_data (out0_data),
    .out_valid(out0_valid),
    .out_last (out0_last),
    .pkt_cnt  (pkt_cnt0),
    .can_load (can_load0)
  );

  demux_out_stage #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_stage1 (
    .clk      (clk),
    .reset    (reset),
    .load     (load1),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_ready(out1_ready),
    .out_data (out1_data),
    .out_valid(out1_valid),
    .out_last (out1_last),
    .pkt_cnt  (pkt_cnt1),
    .can_load (can_load1)
  );

endmodule
